// File: rtl/stream_traffic_gen.sv
// Programmable AXI-Stream frame source driven by a single 64-bit cfg message.
// Define STREAM_TRAFFIC_GEN_LFSR_EN to replace the incrementing payload with a 32-bit Galois LFSR.
//
// state | meaning
// IDLE  | waiting for cfg; cfg_TREADY high except in the done cycle
// SEND  | presenting beats; advances only on tvalid && tready
// GAP   | inter-frame idle, tvalid low, tready ignored
module stream_traffic_gen #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [63:0]             cfg_TDATA,
    input  logic                    cfg_TVALID,
    output logic                    cfg_TREADY,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done
);

    localparam int KW    = DATA_WIDTH / 8;
    localparam int LANES = DATA_WIDTH / 32;

`ifdef STREAM_TRAFFIC_GEN_LFSR_EN
    localparam logic [31:0] PAYLOAD_SEED = 32'hACE1_ACE1;
`else
    localparam logic [31:0] PAYLOAD_SEED = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    function automatic logic [DATA_WIDTH-1:0] lanes_of(input logic [31:0] p);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef STREAM_TRAFFIC_GEN_LFSR_EN
            d[i*32 +: 32] = p ^ 32'(i);
`else
            d[i*32 +: 32] = p;
`endif
        end
        return d;
    endfunction

    function automatic logic [31:0] payload_next(input logic [31:0] p);
`ifdef STREAM_TRAFFIC_GEN_LFSR_EN
        return p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
`else
        return p + 32'd1;
`endif
    endfunction

    // 0 or a count covering the whole bus both mean a full last beat
    function automatic logic [KW-1:0] keep_mask(input logic [7:0] n);
        logic [KW-1:0] m;
        m = '0;
        if (n == 8'd0 || int'(n) >= KW) begin
            m = '1;
        end else begin
            for (int i = 0; i < KW; i++) begin
                m[i] = (i < int'(n));
            end
        end
        return m;
    endfunction

    state_t          state;
    logic            cfg_ready;
    logic [15:0]     beats_m1;
    logic [15:0]     gap_len;
    logic [15:0]     frames;
    logic [KW-1:0]   last_mask;
    logic [15:0]     beat_idx;
    logic [15:0]     frame_idx;
    logic [15:0]     gap_cnt;
    logic [31:0]     payload;

    logic [15:0]     c_beats_m1;
    logic [KW-1:0]   c_mask;
    logic [31:0]     pay_next;
    logic [15:0]     beat_next;
    logic            cfg_unused;

    assign c_beats_m1 = (cfg_TDATA[15:0] == 16'd0) ? 16'd0 : cfg_TDATA[15:0] - 16'd1;
    assign c_mask     = keep_mask(cfg_TDATA[55:48]);
    assign pay_next   = payload_next(payload);
    assign beat_next  = beat_idx + 16'd1;
    assign cfg_unused = ^cfg_TDATA[63:56];

    assign cfg_TREADY = cfg_ready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            cfg_ready     <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            beats_m1      <= '0;
            gap_len       <= '0;
            frames        <= '0;
            last_mask     <= '0;
            beat_idx      <= '0;
            frame_idx     <= '0;
            gap_cnt       <= '0;
            payload       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_TVALID && cfg_ready) begin
                        beats_m1  <= c_beats_m1;
                        gap_len   <= cfg_TDATA[31:16];
                        frames    <= cfg_TDATA[47:32];
                        last_mask <= c_mask;
                        beat_idx  <= '0;
                        frame_idx <= '0;
                        payload   <= PAYLOAD_SEED;
                        if (cfg_TDATA[47:32] == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state         <= SEND;
                            busy          <= 1'b1;
                            cfg_ready     <= 1'b0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= lanes_of(PAYLOAD_SEED);
                            m_axis_tlast  <= (c_beats_m1 == 16'd0);
                            m_axis_tkeep  <= (c_beats_m1 == 16'd0) ? c_mask : '1;
                        end
                    end
                end

                SEND: begin
                    if (m_axis_tready) begin
                        payload <= pay_next;
                        if (m_axis_tlast) begin
                            frame_idx <= frame_idx + 16'd1;
                            beat_idx  <= '0;
                            if (frame_idx + 16'd1 == frames) begin
                                // cfg_ready stays low for the done cycle and rises in IDLE next cycle
                                state         <= IDLE;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tdata  <= '0;
                                m_axis_tkeep  <= '0;
                                m_axis_tlast  <= 1'b0;
                            end else if (gap_len == 16'd0) begin
                                m_axis_tdata <= lanes_of(pay_next);
                                m_axis_tlast <= (beats_m1 == 16'd0);
                                m_axis_tkeep <= (beats_m1 == 16'd0) ? last_mask : '1;
                            end else begin
                                state         <= GAP;
                                m_axis_tvalid <= 1'b0;
                                gap_cnt       <= gap_len;
                            end
                        end else begin
                            beat_idx     <= beat_next;
                            m_axis_tdata <= lanes_of(pay_next);
                            m_axis_tlast <= (beat_next == beats_m1);
                            m_axis_tkeep <= (beat_next == beats_m1) ? last_mask : '1;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == 16'd1) begin
                        state         <= SEND;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= lanes_of(payload);
                        m_axis_tlast  <= (beats_m1 == 16'd0);
                        m_axis_tkeep  <= (beats_m1 == 16'd0) ? last_mask : '1;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
